// File: rtl/gdsp_pkg.sv
// Shared 16-QAM definitions for the TX mapper/upsampler and the RX slicer.
// Holds the Gray level table, sample and symbol types and the per-pair mapping function.
package gdsp_pkg;

    localparam int SPS          = 4;
    localparam int DATA_WIDTH   = 12;
    localparam int BITS_PER_SYM = 4;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic [BITS_PER_SYM-1:0]      qam_sym_t;

    // Q1.11 levels: +/-3 and +/-1 scaled so the outer point sits near 0.95 full scale
    localparam sample_t QAM_NEG3 = sample_t'(-1943);
    localparam sample_t QAM_NEG1 = sample_t'(-648);
    localparam sample_t QAM_POS1 = sample_t'(648);
    localparam sample_t QAM_POS3 = sample_t'(1943);

    // Gray-coded bit pair to amplitude level; adjacent levels differ in one bit
    function automatic sample_t qam_gray_level(input logic [1:0] pair);
        sample_t level;
        level = QAM_NEG3;
        case (pair)
            2'b00:   level = QAM_NEG3;
            2'b01:   level = QAM_NEG1;
            2'b11:   level = QAM_POS1;
            2'b10:   level = QAM_POS3;
            default: level = QAM_NEG3;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/qam16_gray_mapper.sv
// Combinational 16-QAM Gray mapper: symbol {b3,b2,b1,b0} -> I from b3b2, Q from b1b0.
// Shared between the TX upsampler and the RX decision/EVM path.
module qam16_gray_mapper
    import gdsp_pkg::*;
(
    input  qam_sym_t sym,
    output sample_t  in_phase,
    output sample_t  quadrature
);

    sample_t level [2];

    // Lane 0 takes the upper bit pair (I), lane 1 the lower pair (Q)
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign level[gi] = qam_gray_level(sym[BITS_PER_SYM-1-2*gi -: 2]);
        end
    endgenerate

    assign in_phase   = level[0];
    assign quadrature = level[1];

endmodule

// File: rtl/qam16_symbol_upsampler.sv
// Serial-bit to 16-QAM symbol packer, Gray mapper and zero-stuffing upsampler (SPS samples/symbol).
// Optional GDSP_MAPPER_STATS_EN adds sym_count and underrun_count statistics ports.
module qam16_symbol_upsampler #(
    parameter int SPS        = gdsp_pkg::SPS,
    parameter int DATA_WIDTH = gdsp_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_bit,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_i,
    output logic [DATA_WIDTH-1:0] out_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sym_strobe
`ifdef GDSP_MAPPER_STATS_EN
    ,
    output logic [15:0]           sym_count,
    output logic [15:0]           underrun_count
`endif
);

    import gdsp_pkg::*;

    localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int CW = $clog2(BITS_PER_SYM);
    localparam logic [PW-1:0] PHASE_LAST = PW'(SPS - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(BITS_PER_SYM - 1);

    logic [CW-1:0]             bit_cnt_reg, bit_cnt_next;
    logic [BITS_PER_SYM-2:0]   shift_reg, shift_next;
    qam_sym_t                  sym_reg, sym_next;
    logic                      sym_full_reg, sym_full_next;
    logic [PW-1:0]             phase_reg, phase_next;
    logic                      ready_en_reg;

    logic                      at_sym_phase;
    logic                      accept;
    logic                      load;
    logic                      consume;
    sample_t                   map_i;
    sample_t                   map_q;

    qam16_gray_mapper u_mapper (
        .sym        (sym_reg),
        .in_phase   (map_i),
        .quadrature (map_q)
    );

    // ready_en holds in_ready low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    assign at_sym_phase = (phase_reg == '0);
    assign out_valid    = at_sym_phase ? sym_full_reg : 1'b1;
    assign in_ready     = ready_en_reg && !clear &&
                          ((bit_cnt_reg != CNT_LAST) || !sym_full_reg);
    assign accept       = in_valid && in_ready;
    assign load         = accept && (bit_cnt_reg == CNT_LAST);
    assign consume      = out_valid && out_ready;
    assign sym_strobe   = consume && at_sym_phase;

    // Only the phase-0 sample carries the symbol; every other phase is a stuffed zero
    assign out_i = (at_sym_phase && sym_full_reg) ? DATA_WIDTH'(map_i) : '0;
    assign out_q = (at_sym_phase && sym_full_reg) ? DATA_WIDTH'(map_q) : '0;

    always_comb begin
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        sym_next      = sym_reg;
        sym_full_next = sym_full_reg;
        phase_next    = phase_reg;

        if (clear) begin
            bit_cnt_next  = '0;
            shift_next    = '0;
            sym_full_next = 1'b0;
            phase_next    = '0;
        end else begin
            if (consume) begin
                if (at_sym_phase) begin
                    sym_full_next = 1'b0;
                end
                phase_next = (phase_reg == PHASE_LAST) ? '0 : phase_reg + 1'b1;
            end
            // A load can only coincide with a phase-0 consume when sym_full was already clear
            if (accept) begin
                if (load) begin
                    sym_next      = {shift_reg, in_bit};
                    sym_full_next = 1'b1;
                    bit_cnt_next  = '0;
                    shift_next    = '0;
                end else begin
                    shift_next   = {shift_reg[BITS_PER_SYM-3:0], in_bit};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            sym_reg      <= '0;
            sym_full_reg <= 1'b0;
            phase_reg    <= '0;
        end else begin
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            sym_reg      <= sym_next;
            sym_full_reg <= sym_full_next;
            phase_reg    <= phase_next;
        end
    end

`ifdef GDSP_MAPPER_STATS_EN
    logic [15:0] sym_count_reg, sym_count_next;
    logic [15:0] underrun_count_reg, underrun_count_next;
    logic        underrun;

    // An underrun is a cycle where the FIR wanted a symbol sample but none was pending
    assign underrun = at_sym_phase && !sym_full_reg && out_ready;

    always_comb begin
        sym_count_next      = sym_count_reg;
        underrun_count_next = underrun_count_reg;
        if (clear) begin
            sym_count_next      = '0;
            underrun_count_next = '0;
        end else begin
            if (sym_strobe) begin
                sym_count_next = sym_count_reg + 16'd1;
            end
            if (underrun && (underrun_count_reg != 16'hFFFF)) begin
                underrun_count_next = underrun_count_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_count_reg      <= '0;
            underrun_count_reg <= '0;
        end else begin
            sym_count_reg      <= sym_count_next;
            underrun_count_reg <= underrun_count_next;
        end
    end

    assign sym_count      = sym_count_reg;
    assign underrun_count = underrun_count_reg;
`endif

endmodule

// File: tb/tb_qam16_symbol_upsampler.sv
// Scoreboard bench for qam16_symbol_upsampler; stats checks compiled with GDSP_MAPPER_STATS_EN.
`timescale 1ns/1ps
module tb_qam16_symbol_upsampler;

    localparam int SPS = 4;
    localparam int DW  = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_bit = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          sym_strobe;
    logic [DW-1:0] out_i;
    logic [DW-1:0] out_q;
`ifdef GDSP_MAPPER_STATS_EN
    logic [15:0]   sym_count;
    logic [15:0]   underrun_count;
`endif

    typedef struct {
        int i;
        int q;
        bit strobe;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   strobe_cnt = 0;

    // Hand-computed Gray table indexed by symbol {b3,b2,b1,b0}
    int ti [16] = '{-1943, -1943, -1943, -1943, -648, -648, -648, -648,
                     1943,  1943,  1943,  1943,  648,  648,  648,  648};
    int tq [16] = '{-1943,  -648,  1943,   648, -1943, -648, 1943,  648,
                    -1943,  -648,  1943,   648, -1943, -648, 1943,  648};

    always #5 clk = ~clk;

    qam16_symbol_upsampler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .in_bit         (in_bit),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_i          (out_i),
        .out_q          (out_q),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .sym_strobe     (sym_strobe)
`ifdef GDSP_MAPPER_STATS_EN
        ,
        .sym_count      (sym_count),
        .underrun_count (underrun_count)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push_sym(input int ei, input int eq);
        exp_t e;
        e.i = ei; e.q = eq; e.strobe = 1'b1;
        sb.push_back(e);
        for (int k = 1; k < SPS; k++) begin
            e.i = 0; e.q = 0; e.strobe = 1'b0;
            sb.push_back(e);
        end
    endtask

    // Drive at negedge, return just after the accepting posedge
    task automatic send_bit(input logic b);
        int   waited;
        logic acc;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
        #1 acc = in_ready;
        while (!acc && waited < 200) begin
            @(negedge clk);
            #1 acc = in_ready;
            waited++;
        end
        check("bit_accepted", int'(acc), 1);
        @(posedge clk);
    endtask

    task automatic send_sym(input logic [3:0] s, input bit push);
        if (push) push_sym(ti[s], tq[s]);
        for (int b = 3; b >= 0; b--) send_bit(s[b]);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk); #3;
            n++;
        end
        check(name, sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_depth(input int depth);
        int n;
        n = 0;
        while (sb.size() != depth && n < 100) begin
            @(negedge clk); #3;
            n++;
        end
        check("sb_depth_reached", sb.size(), depth);
    endtask

    // Monitor: pops one expected sample per consumed output
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (out_valid && out_ready) begin
                $display("[%0t] sample i=%0d q=%0d strobe=%0b", $time,
                         int'($signed(out_i)), int'($signed(out_q)), sym_strobe);
                strobe_cnt += int'(sym_strobe);
                check("sample_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out_i", int'($signed(out_i)), e.i);
                    check("out_q", int'($signed(out_q)), e.q);
                    check("sym_strobe", int'(sym_strobe), int'(e.strobe));
                end
            end else if (!out_valid) begin
                check("idle_outputs_zero", int'(out_i != '0 || out_q != '0 || sym_strobe), 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          s0;
        int          idx;
        int          stable_bad;
        int          n;
        bit          held;
        int          held_i;
        int          held_q;
        logic [7:0]  stream;
        logic [3:0]  usyms [2];
        logic [3:0]  sym;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_i", int'(out_i), 0);
        check("rst_sym_strobe", int'(sym_strobe), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("in_ready_before_first_edge", int'(in_ready), 0);
        @(negedge clk); #1;
        check("in_ready_after_release", int'(in_ready), 1);
        out_ready = 1'b1;

        // Symbol 0000: one-cycle latency and one strobe
        s0 = strobe_cnt;
        send_sym(4'b0000, 1'b1);
        #1;
        check("latency_valid", int'(out_valid), 1);
        check("latency_i", int'($signed(out_i)), -1943);
        check("latency_q", int'($signed(out_q)), -1943);
        wait_drain("drain_sym0");
        check("strobe_once", strobe_cnt - s0, 1);

        // All 16 symbols against the Gray table
        for (int k = 0; k < 16; k++) begin
            sym = k[3:0];
            send_sym(sym, 1'b1);
        end
        wait_drain("drain_all16");

        // Backpressure: 7 bits accepted, outputs held, order preserved
        stream = 8'b1011_0110;
        push_sym(1943, 648);
        push_sym(-648, 1943);
        @(negedge clk);
        out_ready  = 1'b0;
        idx        = 0;
        stable_bad = 0;
        held       = 1'b0;
        held_i     = 0;
        held_q     = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = (idx < 8) ? stream[7-idx] : 1'b0;
            #1;
            if (in_ready) idx++;
            if (out_valid) begin
                if (!held) begin
                    held   = 1'b1;
                    held_i = int'($signed(out_i));
                    held_q = int'($signed(out_q));
                end else if (int'($signed(out_i)) != held_i || int'($signed(out_q)) != held_q) begin
                    stable_bad++;
                end
            end
        end
        check("bp_bits_accepted", idx, 7);
        check("bp_in_ready_low", int'(in_ready), 0);
        check("bp_out_valid", int'(out_valid), 1);
        check("bp_held_i", held_i, 1943);
        check("bp_held_q", held_q, 648);
        check("bp_stable", stable_bad, 0);
        n = 0;
        while (idx < 8 && n < 50) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_bit    = stream[7-idx];
            #1;
            if (in_ready) idx++;
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_release_bits", idx, 8);
        wait_drain("drain_bp");

        // Underrun: one bit every 8 cycles, no extra zeros
        usyms[0] = 4'b1100;
        usyms[1] = 4'b0011;
        s0 = strobe_cnt;
        for (int k = 0; k < 2; k++) begin
            sym = usyms[k];
            #1 check("underrun_out_valid", int'(out_valid), 0);
            push_sym(ti[sym], tq[sym]);
            for (int b = 3; b >= 0; b--) begin
                send_bit(sym[b]);
                @(negedge clk);
                in_valid = 1'b0;
                repeat (6) @(negedge clk);
            end
        end
        wait_drain("drain_underrun");
        check("underrun_strobes", strobe_cnt - s0, 2);

        // Reset after 2 bits
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_sym(4'b0101, 1'b1);
        wait_drain("drain_after_rst_bits");

        // Reset at phase 2
        send_sym(4'b1110, 1'b1);
        wait_depth(1);
        check("ph2_valid_before_rst", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("ph2_rst_out_valid", int'(out_valid), 0);
        check("ph2_rst_out_i", int'(out_i), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_sym(4'b0010, 1'b1);
        wait_drain("drain_after_rst_ph2");

        // Clear after 2 bits; bit presented during clear is dropped
        send_bit(1'b0);
        send_bit(1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        clear    = 1'b1;
        #1 check("clear_in_ready", int'(in_ready), 0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        send_sym(4'b1000, 1'b1);
        wait_drain("drain_after_clear_bits");

        // Clear at phase 2
        send_sym(4'b1111, 1'b1);
        wait_depth(1);
        check("ph2_valid_before_clear", int'(out_valid), 1);
        out_ready = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1 check("ph2_clear_out_valid", int'(out_valid), 0);
        sb.delete();
        out_ready = 1'b1;
        send_sym(4'b0111, 1'b1);
        wait_drain("drain_after_clear_ph2");

`ifdef GDSP_MAPPER_STATS_EN
        // 100 symbols without underrun, then 5 underrun cycles
        @(negedge clk);
        out_ready = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int k = 0; k < 100; k++) begin
            sym = k[3:0];
            send_sym(sym, 1'b1);
            out_ready = 1'b1;
            repeat (SPS) @(negedge clk);
            out_ready = 1'b0;
        end
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("stats_sym_count", int'(sym_count), 100);
        check("stats_underrun_count", int'(underrun_count), 5);
        check("stats_sb_empty", sb.size(), 0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("stats_clear_sym_count", int'(sym_count), 0);
        check("stats_clear_underrun", int'(underrun_count), 0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/qam16_symbol_upsampler.md
Name: qam16_symbol_upsampler

Overview:
- Upstream TX stage that feeds the RRC pulse-shaping FIR.
- Packs a serial PRBS bit stream into 4-bit 16-QAM symbols and Gray-maps each symbol to Q1.11 I/Q levels.
- Zero-stuffs the output to SPS samples per symbol, so the FIR sees one impulse per symbol period.
- Valid/ready handshakes on both sides, so either side can stall the chain without losing data.

Parameters:
- SPS, 4: samples per symbol (≥2); output phase counter modulus.
- DATA_WIDTH, 12: I/Q sample width, signed Q1.11.

Ports:
- clk  in  1  system clock, 27 MHz domain.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of collector, pending symbol and phase.
- in_bit  in  1  serial data bit.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  stage accepts a bit this cycle.
- out_i  out  DATA_WIDTH  signed I sample.
- out_q  out  DATA_WIDTH  signed Q sample.
- out_valid  out  1  out_i/out_q are valid.
- out_ready  in  1  FIR consumes the sample this cycle.
- sym_strobe  out  1  high on the cycle a phase-0 (symbol) sample is consumed.

Behaviour:
- Reset (rst_n=0, async): bit_cnt=0, shift register=0, sym_full=0, phase=0. All outputs are 0, including in_ready; in_ready rises on the first clock after reset release.
- Collector:
  - A bit is accepted when in_valid&&in_ready; the first accepted bit becomes symbol MSB b3.
  - bit_cnt counts 0..3. On the 4th accepted bit, {b3..b0} loads the symbol register, sym_full←1 and bit_cnt←0.
- in_ready = !clear && ((bit_cnt!=3) || !sym_full). It depends on registers and clear only; there is no combinational path from out_ready.
- Mapping, Gray coded, pair→level:
  - 00→QAM_NEG3 (−1943), 01→QAM_NEG1 (−648), 11→QAM_POS1 (+648), 10→QAM_POS3 (+1943).
  - I uses b3b2; Q uses b1b0.
- Upsampler, with phase counting 0..SPS−1:
  - phase==0: out_valid=sym_full; out_i/out_q = mapped levels.
  - phase≠0: out_valid=1; out_i=out_q=0.
  - phase advances only on out_valid&&out_ready, and wraps SPS−1→0.
  - A consume at phase 0 clears sym_full and pulses sym_strobe.
- Simultaneous 4th-bit accept and phase-0 consume: only possible when sym_full=0 or bit_cnt≠3, so no conflict. A new symbol may load on the same edge the previous one is consumed only if in_ready was already high.
- Latency: the 4th bit is accepted at edge N; the first phase-0 sample is valid after edge N (next cycle).
- Underrun: at phase 0 with sym_full=0, out_valid=0 and phase holds. Zeros are never emitted in place of a missing symbol.
- Backpressure: while out_ready=0, out_i/out_q/out_valid are held stable. The collector may still fill one pending symbol plus 3 bits, then in_ready drops.
- clear=1 at an edge: bit_cnt, sym_full and phase go to 0. A bit presented during clear is dropped (in_ready=0 then). clear takes precedence over all other updates.
- Outputs decode from registers only; out_i/out_q are 0 whenever out_valid=0.

Optional Feature:
- Macro: GDSP_MAPPER_STATS_EN.
- When defined:
  - Adds sym_count (out, 16 bits): counts phase-0 consumes and wraps 0xFFFF→0.
  - Adds underrun_count (out, 16 bits): counts cycles with phase==0 && !sym_full && out_ready; saturates at 0xFFFF.
  - Both counters are reset by rst_n and clear.
- When undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package (gdsp_pkg):
  - Reuse QAM_NEG3/NEG1/POS1/POS3, SPS, DATA_WIDTH and sample_t.
  - Add typedef qam_sym_t (logic [BITS_PER_SYM-1:0]) and a function qam_gray_level(2-bit) returning sample_t, shared with the receiver slicer.
- Sub-module: qam16_gray_mapper, purely combinational (4-bit symbol → I/Q sample_t). It is instantiated here and reused by the RX decision/EVM logic.

Test Plan:
- Bits 0,0,0,0 with out_ready=1 → next cycle I=Q=−1943 out_valid=1, then three samples I=Q=0, sym_strobe=1 exactly once.
- Bits 1,0,1,1 → I=+1943, Q=+648; bits 0,1,1,0 → I=−648, Q=+1943; all 16 symbols are checked against the Gray table.
- out_ready=0 for 20 cycles with in_valid=1 → in_ready drops after 7 bits accepted (4 pending + 3), outputs stable; on release the symbol order is preserved.
- in_valid pulsed 1 bit every 8 cycles → phase-0 underrun: out_valid=0 at phase 0, no extra zeros, and exactly SPS samples per symbol.
- rst_n asserted mid-symbol after 2 bits and at phase 2 → outputs 0 immediately; the next 4 bits form a fresh symbol. Same check with clear=1 for one cycle.
- With GDSP_MAPPER_STATS_EN: 100 symbols plus 5 underrun cycles → sym_count=100, underrun_count=5; clear → both 0.
